// File: rtl/vram_pkg.sv
// Shared definitions for the VRAM drawing engines: framebuffer geometry
// defaults, RGB332 pixel layout, walker state encoding and the rectangle
// command record (also reused by the blit and line engines).
package vram_pkg;
    localparam int FB_WIDTH_DEF  = 320;
    localparam int FB_HEIGHT_DEF = 240;
    localparam int VRAM_ADDR_W   = 18;

    localparam int RGB332_R_W = 3;
    localparam int RGB332_G_W = 3;
    localparam int RGB332_B_W = 2;
    localparam int PIXEL_W    = RGB332_R_W + RGB332_G_W + RGB332_B_W;

    localparam int COORD_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLIP,
        ST_FILL,
        ST_DONE
    } fill_state_e;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] w;
        logic [COORD_W-1:0] h;
        logic [PIXEL_W-1:0] color;
    } rect_cmd_t;
endpackage

// File: rtl/vram_rect_fill_if.sv
// Command handshake plus VRAM port B write bus of the rectangle filler.
// master = command issuer / VRAM side, slave = the fill engine.
interface vram_rect_fill_if
    import vram_pkg::*;
#(
    parameter int ADDR_W = VRAM_ADDR_W
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic [COORD_W-1:0] cmd_x;
    logic [COORD_W-1:0] cmd_y;
    logic [COORD_W-1:0] cmd_w;
    logic [COORD_W-1:0] cmd_h;
    logic [PIXEL_W-1:0] cmd_color;
    logic [ADDR_W-1:0]  ADDR_B;
    logic [PIXEL_W-1:0] DATA_B;
    logic               WE_B;

    modport master (
        output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
        input  cmd_ready, ADDR_B, DATA_B, WE_B
    );

    modport slave (
        input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
        output cmd_ready, ADDR_B, DATA_B, WE_B
    );
endinterface

// File: rtl/vram_rect_clip.sv
// Combinational clip / reject evaluation of a latched rectangle command.
// Config macro VRAM_RECT_CLIP_EN: when defined, rectangles running past the
// framebuffer edge are clipped; otherwise they are rejected outright.
module vram_rect_clip
    import vram_pkg::*;
#(
    parameter int FB_WIDTH  = FB_WIDTH_DEF,
    parameter int FB_HEIGHT = FB_HEIGHT_DEF
) (
    input  rect_cmd_t        cmd,
    output logic [COORD_W:0] xe,
    output logic [COORD_W:0] ye,
    output logic             empty,
    output logic             reject
);
    localparam logic [COORD_W:0] FB_W = (COORD_W+1)'(FB_WIDTH);
    localparam logic [COORD_W:0] FB_H = (COORD_W+1)'(FB_HEIGHT);

    logic [COORD_W:0] sum_x;
    logic [COORD_W:0] sum_y;

    // One extra bit on the sums so x+w never wraps before the compare.
    always_comb begin
        sum_x  = {1'b0, cmd.x} + {1'b0, cmd.w};
        sum_y  = {1'b0, cmd.y} + {1'b0, cmd.h};
        xe     = (sum_x > FB_W) ? FB_W : sum_x;
        ye     = (sum_y > FB_H) ? FB_H : sum_y;
        empty  = (cmd.w == '0) || (cmd.h == '0) ||
                 ({1'b0, cmd.x} >= FB_W) || ({1'b0, cmd.y} >= FB_H);
`ifdef VRAM_RECT_CLIP_EN
        reject = 1'b0;
`else
        reject = (sum_x > FB_W) || (sum_y > FB_H);
`endif
    end
endmodule

// File: rtl/vram_rect_fill.sv
// Rectangle fill engine: accepts a rectangle command, clips/rejects it in
// one cycle, then writes one RGB332 byte per clock on VRAM port B, row by
// row, with no bubbles. Row base address is multiplied once and then
// accumulated per row. Config macro: VRAM_RECT_CLIP_EN (see vram_rect_clip).
module vram_rect_fill
    import vram_pkg::*;
#(
    parameter int FB_WIDTH  = FB_WIDTH_DEF,
    parameter int FB_HEIGHT = FB_HEIGHT_DEF,
    parameter int BASE_ADDR = 0,
    parameter int ADDR_W    = VRAM_ADDR_W
) (
    input  logic                   CLK,
    input  logic                   RST,
    vram_rect_fill_if.slave        bus,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(FB_WIDTH);
    localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE_ADDR);
    localparam logic [COORD_W:0]  ONE_E    = (COORD_W+1)'(1);

    fill_state_e        state_reg, state_next;
    rect_cmd_t          cmd_reg, cmd_next;
    logic [COORD_W:0]   xe_reg, xe_next;
    logic [COORD_W:0]   ye_reg, ye_next;
    logic [COORD_W-1:0] cx_reg, cx_next;
    logic [COORD_W-1:0] cy_reg, cy_next;
    logic [ADDR_W-1:0]  row_base_reg, row_base_next;
    logic               err_reg, err_next;

    logic [COORD_W:0]   clip_xe, clip_ye;
    logic               clip_empty, clip_reject;
    logic               ready, we;
    logic [ADDR_W-1:0]  addr;
    logic [PIXEL_W-1:0] wdata;
    logic               last_col, last_row;

    vram_rect_clip #(
        .FB_WIDTH  (FB_WIDTH),
        .FB_HEIGHT (FB_HEIGHT)
    ) u_clip (
        .cmd    (cmd_reg),
        .xe     (clip_xe),
        .ye     (clip_ye),
        .empty  (clip_empty),
        .reject (clip_reject)
    );

    assign last_col = ({1'b0, cx_reg} == (xe_reg - ONE_E));
    assign last_row = ({1'b0, cy_reg} == (ye_reg - ONE_E));

    assign bus.cmd_ready = ready;
    assign bus.WE_B      = we;
    assign bus.ADDR_B    = addr;
    assign bus.DATA_B    = wdata;

    // State and walker registers; reset abandons any command in flight.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg    <= ST_IDLE;
            cmd_reg      <= '0;
            xe_reg       <= '0;
            ye_reg       <= '0;
            cx_reg       <= '0;
            cy_reg       <= '0;
            row_base_reg <= '0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cmd_reg      <= cmd_next;
            xe_reg       <= xe_next;
            ye_reg       <= ye_next;
            cx_reg       <= cx_next;
            cy_reg       <= cy_next;
            row_base_reg <= row_base_next;
            err_reg      <= err_next;
        end
    end

    // Next-state, walker update and Moore outputs of the fill FSM.
    always_comb begin
        state_next    = state_reg;
        cmd_next      = cmd_reg;
        xe_next       = xe_reg;
        ye_next       = ye_reg;
        cx_next       = cx_reg;
        cy_next       = cy_reg;
        row_base_next = row_base_reg;
        err_next      = err_reg;
        ready         = 1'b0;
        we            = 1'b0;
        addr          = '0;
        wdata         = '0;
        busy          = 1'b0;
        done          = 1'b0;
        err           = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                ready = 1'b1;
                if (bus.cmd_valid) begin
                    cmd_next.x     = bus.cmd_x;
                    cmd_next.y     = bus.cmd_y;
                    cmd_next.w     = bus.cmd_w;
                    cmd_next.h     = bus.cmd_h;
                    cmd_next.color = bus.cmd_color;
                    state_next     = ST_CLIP;
                end
            end
            ST_CLIP: begin
                busy          = 1'b1;
                xe_next       = clip_xe;
                ye_next       = clip_ye;
                cx_next       = cmd_reg.x;
                cy_next       = cmd_reg.y;
                row_base_next = BASE_A + ADDR_W'(cmd_reg.y) * ROW_STEP;
                err_next      = clip_reject;
                if (clip_reject || clip_empty) begin
                    state_next = ST_DONE;
                end else begin
                    state_next = ST_FILL;
                end
            end
            ST_FILL: begin
                busy  = 1'b1;
                we    = 1'b1;
                addr  = row_base_reg + ADDR_W'(cx_reg);
                wdata = cmd_reg.color;
                if (last_col) begin
                    cx_next       = cmd_reg.x;
                    cy_next       = cy_reg + 1'b1;
                    row_base_next = row_base_reg + ROW_STEP;
                    if (last_row) begin
                        state_next = ST_DONE;
                    end
                end else begin
                    cx_next = cx_reg + 1'b1;
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                err        = err_reg;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_vram_rect_fill.sv
// Scoreboard bench for vram_rect_fill. Expected writes and done/err results
// are queued when a command is issued; a monitor pops and compares them as
// the DUT writes. A second instance with a small frame and nonzero base
// address is filled completely and checked against an address bitmap.
module tb_vram_rect_fill;
    import vram_pkg::*;

    localparam int B_W    = 40;
    localparam int B_H    = 30;
    localparam int B_BASE = 76800;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    vram_rect_fill_if #(.ADDR_W(18)) bus_a ();
    vram_rect_fill_if #(.ADDR_W(18)) bus_b ();
    logic busy_a, done_a, err_a;
    logic busy_b, done_b, err_b;

    vram_rect_fill #(.FB_WIDTH(320), .FB_HEIGHT(240), .BASE_ADDR(0), .ADDR_W(18)) dut_a (
        .CLK(CLK), .RST(RST), .bus(bus_a.slave), .busy(busy_a), .done(done_a), .err(err_a)
    );
    vram_rect_fill #(.FB_WIDTH(B_W), .FB_HEIGHT(B_H), .BASE_ADDR(B_BASE), .ADDR_W(18)) dut_b (
        .CLK(CLK), .RST(RST), .bus(bus_b.slave), .busy(busy_b), .done(done_b), .err(err_b)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        int addr;
        int data;
    } wr_t;
    wr_t exp_wr_q[$];
    bit  exp_done_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s", name);
    endtask

    // Reference model for the 320x240 instance: queue every pixel address
    // and the expected completion status.
    task automatic push_rect_a(input int x, input int y, input int w, input int h, input int c);
        int  sx, sy, xe, ye;
        bit  rej;
        wr_t e;
        sx = x + w;
        sy = y + h;
`ifdef VRAM_RECT_CLIP_EN
        rej = 1'b0;
`else
        rej = (sx > 320) || (sy > 240);
`endif
        if (!rej) begin
            xe = (sx > 320) ? 320 : sx;
            ye = (sy > 240) ? 240 : sy;
            for (int r = y; r < ye; r++) begin
                for (int col = x; col < xe; col++) begin
                    e.addr = r * 320 + col;
                    e.data = c;
                    exp_wr_q.push_back(e);
                end
            end
        end
        exp_done_q.push_back(rej);
    endtask

    task automatic drive_a(input int x, input int y, input int w, input int h, input int c);
        bus_a.cmd_x     = 10'(x);
        bus_a.cmd_y     = 10'(y);
        bus_a.cmd_w     = 10'(w);
        bus_a.cmd_h     = 10'(h);
        bus_a.cmd_color = 8'(c);
    endtask

    // Monitor for instance A: pops the scoreboard on each write / done.
    wr_t mon_e;
    bit  mon_err;
    always @(negedge CLK) begin
        if (bus_a.WE_B === 1'b1) begin
            if (exp_wr_q.size() == 0) begin
                fail_now($sformatf("unexpected_write addr=%0d", bus_a.ADDR_B));
            end else begin
                mon_e = exp_wr_q.pop_front();
                check("wr_addr", 64'(bus_a.ADDR_B), 64'(mon_e.addr));
                check("wr_data", 64'(bus_a.DATA_B), 64'(mon_e.data));
            end
        end
        if (done_a === 1'b1) begin
            if (exp_done_q.size() == 0) begin
                fail_now("unexpected_done");
            end else begin
                mon_err = exp_done_q.pop_front();
                check("done_err", 64'(err_a), 64'(mon_err));
            end
        end else if (err_a !== 1'b0) begin
            fail_now("err_without_done");
        end
    end

    // Monitor for instance B: every address inside the frame exactly once.
    bit seen_b[B_W*B_H];
    int seen_cnt_b = 0;
    int idx_b;
    always @(negedge CLK) begin
        if (bus_b.WE_B === 1'b1) begin
            idx_b = int'(bus_b.ADDR_B) - B_BASE;
            if (idx_b < 0 || idx_b >= B_W * B_H) begin
                fail_now($sformatf("b_addr_range addr=%0d", bus_b.ADDR_B));
            end else begin
                check("b_addr_once", 64'(seen_b[idx_b]), 64'd0);
                seen_b[idx_b] = 1'b1;
                seen_cnt_b++;
            end
            check("b_data", 64'(bus_b.DATA_B), 64'h1C);
        end
    end

    // Issue one command to A and check timing: first write in cycle 2,
    // contiguous writes, done right after the last write, busy throughout.
    task automatic run_cmd(input string name, input int x, input int y, input int w, input int h,
                           input int c, input int exp_n, input int exp_err);
        int  first, last, n, done_k, err_k;
        bit  busy_ok;
        push_rect_a(x, y, w, h, c);
        @(negedge CLK);
        check({name, "_ready_idle"}, 64'(bus_a.cmd_ready), 64'd1);
        drive_a(x, y, w, h, c);
        bus_a.cmd_valid = 1'b1;
        @(negedge CLK);
        bus_a.cmd_valid = 1'b0;
        first = -1; last = -1; n = 0; done_k = -1; err_k = 0; busy_ok = 1'b1;
        for (int k = 1; k <= 400; k++) begin
            if (k > 1) @(negedge CLK);
            if (bus_a.WE_B === 1'b1) begin
                if (first < 0) first = k;
                last = k;
                n++;
            end
            if (done_a === 1'b1) begin
                done_k = k;
                err_k  = int'(err_a);
                break;
            end
            if (busy_a !== 1'b1 || bus_a.cmd_ready !== 1'b0) busy_ok = 1'b0;
        end
        if (done_k < 0) begin
            fail_now({name, "_timeout"});
        end else begin
            check({name, "_nwrites"}, 64'(n), 64'(exp_n));
            check({name, "_done_cycle"}, 64'(done_k), 64'(2 + exp_n));
            check({name, "_err"}, 64'(err_k), 64'(exp_err));
            check({name, "_busy"}, 64'(busy_ok), 64'd1);
            if (exp_n > 0) begin
                check({name, "_first_we"}, 64'(first), 64'd2);
                check({name, "_no_gaps"}, 64'(last - first + 1), 64'(n));
            end
        end
        @(negedge CLK);
        check({name, "_ready_after"}, 64'(bus_a.cmd_ready), 64'd1);
    endtask

    typedef struct {
        string name;
        int x, y, w, h, c, n, e;
    } vec_t;
    vec_t vecs[$];

    initial begin
        int n_we, done_seen, first_b, last_b, done_kb;
        logic [9:0] we_bits, done_bits, ready_bits, busy_bits;

        bus_a.cmd_valid = 1'b0;
        drive_a(0, 0, 0, 0, 0);
        bus_b.cmd_valid = 1'b0;
        bus_b.cmd_x = '0; bus_b.cmd_y = '0; bus_b.cmd_w = '0; bus_b.cmd_h = '0;
        bus_b.cmd_color = '0;

        // Reset state.
        repeat (3) @(negedge CLK);
        check("rst_ready", 64'(bus_a.cmd_ready), 64'd1);
        check("rst_we",    64'(bus_a.WE_B),      64'd0);
        check("rst_addr",  64'(bus_a.ADDR_B),    64'd0);
        check("rst_data",  64'(bus_a.DATA_B),    64'd0);
        check("rst_busy",  64'(busy_a),          64'd0);
        check("rst_done",  64'(done_a),          64'd0);
        check("rst_err",   64'(err_a),           64'd0);
        RST = 1'b0;

        // Directed vectors with hand-computed write counts and err.
        vecs.push_back('{"basic",   2,   3,   4, 2, 8'hE0, 8,   0});
`ifdef VRAM_RECT_CLIP_EN
        vecs.push_back('{"clip",    318, 239, 5, 5, 8'h3F, 2,   0});
        vecs.push_back('{"x320",    320, 0,   1, 1, 8'h11, 0,   0});
`else
        vecs.push_back('{"clip",    318, 239, 5, 5, 8'h3F, 0,   1});
        vecs.push_back('{"x320",    320, 0,   1, 1, 8'h11, 0,   1});
`endif
        vecs.push_back('{"w0",      5,   5,   0, 3, 8'h22, 0,   0});
        vecs.push_back('{"h0",      7,   7,   3, 0, 8'h33, 0,   0});
        vecs.push_back('{"col_edge",319, 0,   1, 3, 8'h44, 3,   0});
        vecs.push_back('{"last_row",0,   239, 320, 1, 8'h92, 320, 0});
        foreach (vecs[i]) begin
            run_cmd(vecs[i].name, vecs[i].x, vecs[i].y, vecs[i].w, vecs[i].h,
                    vecs[i].c, vecs[i].n, vecs[i].e);
        end

        // Back-to-back: valid held high across two 1x1 commands.
        push_rect_a(10, 10, 1, 1, 8'h55);
        push_rect_a(20, 20, 1, 1, 8'hAA);
        @(negedge CLK);
        drive_a(10, 10, 1, 1, 8'h55);
        bus_a.cmd_valid = 1'b1;
        we_bits = '0; done_bits = '0; ready_bits = '0; busy_bits = '0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge CLK);
            if (k == 1) drive_a(20, 20, 1, 1, 8'hAA);
            we_bits[k-1]    = bus_a.WE_B;
            done_bits[k-1]  = done_a;
            ready_bits[k-1] = bus_a.cmd_ready;
            busy_bits[k-1]  = busy_a;
            if (k == 5) bus_a.cmd_valid = 1'b0;
        end
        check("b2b_we_pattern",    64'(we_bits),    64'h022);
        check("b2b_done_pattern",  64'(done_bits),  64'h044);
        check("b2b_ready_pattern", 64'(ready_bits), 64'h388);
        check("b2b_busy_pattern",  64'(busy_bits),  64'h033);

        // Reset in the middle of row 2 of a 10x10 fill.
        push_rect_a(0, 0, 10, 10, 8'h77);
        @(negedge CLK);
        drive_a(0, 0, 10, 10, 8'h77);
        bus_a.cmd_valid = 1'b1;
        @(negedge CLK);
        bus_a.cmd_valid = 1'b0;
        n_we = 0;
        for (int k = 0; k < 100 && n_we < 25; k++) begin
            if (k > 0) @(negedge CLK);
            if (bus_a.WE_B === 1'b1) n_we++;
        end
        check("rstmid_reached", 64'(n_we), 64'd25);
        RST = 1'b1;
        @(negedge CLK);
        check("rstmid_we",   64'(bus_a.WE_B), 64'd0);
        check("rstmid_done", 64'(done_a),     64'd0);
        check("rstmid_left", 64'(exp_wr_q.size()), 64'd75);
        exp_wr_q.delete();
        exp_done_q.delete();
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        check("rstmid_ready", 64'(bus_a.cmd_ready), 64'd1);
        done_seen = 0;
        repeat (5) begin
            @(negedge CLK);
            if (done_a === 1'b1) done_seen++;
        end
        check("rstmid_no_done", 64'(done_seen), 64'd0);

        // Full-frame fill on instance B at a nonzero base address.
        @(negedge CLK);
        bus_b.cmd_x = 10'd0; bus_b.cmd_y = 10'd0;
        bus_b.cmd_w = 10'(B_W); bus_b.cmd_h = 10'(B_H);
        bus_b.cmd_color = 8'h1C;
        bus_b.cmd_valid = 1'b1;
        @(negedge CLK);
        bus_b.cmd_valid = 1'b0;
        first_b = -1; last_b = -1; done_kb = -1;
        for (int k = 1; k <= 3000; k++) begin
            if (k > 1) @(negedge CLK);
            if (bus_b.WE_B === 1'b1) begin
                if (first_b < 0) first_b = k;
                last_b = k;
            end
            if (done_b === 1'b1) begin
                done_kb = k;
                check("b_err", 64'(err_b), 64'd0);
                break;
            end
        end
        if (done_kb < 0) begin
            fail_now("b_timeout");
        end else begin
            check("b_count",      64'(seen_cnt_b),          64'(B_W * B_H));
            check("b_no_gaps",    64'(last_b - first_b + 1), 64'(B_W * B_H));
            check("b_first_we",   64'(first_b),             64'd2);
            check("b_done_cycle", 64'(done_kb),             64'(B_W * B_H + 2));
        end

        @(negedge CLK);
        check("sb_writes_drained", 64'(exp_wr_q.size()),   64'd0);
        check("sb_done_drained",   64'(exp_done_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/vram_rect_fill.md
Name: vram_rect_fill

Overview:
- Drawing-side writer for the dual-clock VRAM; it is the write counterpart to the RGB332 scanout, which reads VRAM port A.
- Accepts axis-aligned rectangle fill commands through a valid/ready handshake.
- Walks each rectangle row by row and writes one RGB332 byte per clock on VRAM port B.
- Sits in the CLK (system clock) domain. Its ADDR_B/DATA_B/WE_B drive the currently tied-off port B.

Parameters:
- FB_WIDTH, 320: framebuffer width in pixels (bytes per row).
- FB_HEIGHT, 240: framebuffer height in rows.
- BASE_ADDR, 0: 18-bit VRAM byte address of pixel (0,0).
- ADDR_W, 18: VRAM port B address width.

Ports:
- CLK  input  1  system clock; all logic is on the rising edge.
- RST  input  1  synchronous, active-high reset.
- cmd_valid  input  1  a command is presented.
- cmd_ready  output  1  block can accept a command (high only in IDLE).
- cmd_x  input  10  rectangle left column.
- cmd_y  input  10  rectangle top row.
- cmd_w  input  10  width in pixels.
- cmd_h  input  10  height in rows.
- cmd_color  input  8  RGB332 fill value.
- ADDR_B  output  ADDR_W  VRAM port B byte address.
- DATA_B  output  8  VRAM port B write data.
- WE_B  output  1  VRAM port B write enable.
- busy  output  1  a command is in progress (CLIP or FILL state).
- done  output  1  one-cycle pulse when a command completes.
- err  output  1  one-cycle pulse, coincident with done, when the command was rejected (see Optional Feature).

Behaviour:
- Reset values: cmd_ready=1, WE_B=0, ADDR_B=0, DATA_B=0, busy=0, done=0, err=0; state=IDLE.
- RST asserted mid-fill:
  - WE_B is 0 from the next edge.
  - The command is abandoned and no done pulse is issued.
- Handshake: a command is accepted on the edge where cmd_valid && cmd_ready. Fields are latched on that edge; inputs are don't-care afterwards.
- State IDLE:
  - cmd_ready=1.
  - On accept, go to CLIP.
- State CLIP (1 cycle):
  - Compute xe = min(cmd_x+cmd_w, FB_WIDTH) and ye = min(cmd_y+cmd_h, FB_HEIGHT), using 11-bit sums with no wrap.
  - Empty rectangle: cmd_w==0, cmd_h==0, cmd_x>=FB_WIDTH or cmd_y>=FB_HEIGHT. Go to DONE with no writes.
  - Otherwise set row_base = BASE_ADDR + cmd_y*FB_WIDTH. This is computed once, with a constant multiply, in CLIP only.
  - Set the column counter cx=cmd_x and row counter cy=cmd_y, then go to FILL.
- State FILL, one write per cycle:
  - Outputs: WE_B=1, ADDR_B=row_base+cx, DATA_B=color.
  - cx increments each cycle.
  - When cx==xe-1: cx returns to x0, cy increments, and row_base += FB_WIDTH (accumulated, no multiplier).
  - On the last pixel (cx==xe-1 && cy==ye-1), go to DONE.
- State DONE (1 cycle):
  - done=1, WE_B=0, then go to IDLE.
  - cmd_ready returns to 1 the cycle after DONE.
- Latency:
  - Accept at edge N; first WE_B is visible in the cycle after edge N+1.
  - Writes are exactly (xe-x0)*(ye-y0) consecutive cycles with no bubbles.
  - done follows the last write by one cycle.
- Addresses never exceed BASE_ADDR + FB_WIDTH*FB_HEIGHT - 1. The VRAM write has no back-pressure.
- cmd_valid while busy is ignored because cmd_ready=0. A new command is accepted at the earliest on the cycle after DONE.

Optional Feature:
- Macro: VRAM_RECT_CLIP_EN.
- Defined: out-of-range rectangles are clipped as described above; err stays 0.
- Undefined:
  - CLIP rejects any command with cmd_x+cmd_w > FB_WIDTH or cmd_y+cmd_h > FB_HEIGHT.
  - A rejected command goes directly to DONE with done=1, err=1 and no writes.
  - Empty in-range commands complete with done=1, err=0.

Decomposition:
- Shared package vram_pkg:
  - FB_WIDTH/FB_HEIGHT defaults, RGB332 field widths, VRAM_ADDR_W=18.
  - State encoding typedef (IDLE, CLIP, FILL, DONE).
  - Command struct {x,y,w,h,color}, also used by future blit/line engines.
- Sub-module vram_rect_clip: combinational clip/reject computation (xe, ye, empty, reject) instantiated in CLIP. The walker FSM stays in the top module.

Test Plan:
- Reset mid-fill: RST high during row 2 of a 10x10 fill → WE_B=0 next edge, no done; cmd_ready=1 after RST releases.
- Basic fill: x=2,y=3,w=4,h=2,color=8'hE0 → 8 writes to addresses 962..965 then 1282..1285 with DATA_B=E0; done one cycle after the last write.
- Clipping (CLIP_EN defined): x=318,y=239,w=5,h=5 → exactly 2 writes (76798, 76799); err=0. With CLIP_EN undefined: zero writes, done=err=1.
- Empty command: w=0 → done pulse 2 cycles after accept, no WE_B; x=320,w=1 → same.
- Back-to-back: cmd_valid held high with two 1x1 commands → second accepted only after DONE; writes separated by DONE+CLIP cycles; busy high throughout each command.
- BASE_ADDR=76800 with a full-screen fill of color 8'h1C → 76800 writes spanning 76800..153599 with no gaps; a scoreboard checks every address exactly once.
